// File: rtl/deg_to_theta.sv
// Pops integer degrees from a FIFO, wraps them into [-180,+180] and pushes the
// rounded Q2.14 radian value into the cordic theta FIFO, one sample at a time.
module deg_to_theta #(
  parameter int DEG_W   = 16,
  parameter int THETA_W = 32,
  parameter int K_RAD   = 18740330
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      deg_empty,
  output logic                      deg_rd_en,
  input  logic signed [DEG_W-1:0]   deg_dout,
  input  logic                      theta_full,
  output logic                      theta_wr_en,
  output logic signed [THETA_W-1:0] theta_din,
  output logic                      busy,
  output logic [31:0]               sample_count
);

  localparam int X_W = DEG_W + 2;
  localparam int P_W = DEG_W + 28;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WRAP  = 3'd2;
  localparam logic [2:0] MULT  = 3'd3;
  localparam logic [2:0] PUSH  = 3'd4;

  localparam logic signed [X_W-1:0] DEG_180 = X_W'(180);
  localparam logic signed [X_W-1:0] DEG_360 = X_W'(360);
  localparam logic signed [P_W-1:0] K_S     = P_W'(K_RAD);
  localparam logic signed [P_W-1:0] RND     = P_W'(32768);

  logic [2:0]              state;
  logic signed [X_W-1:0]   x_p0;
  logic signed [16:0]      theta_p1;
  logic                    x_hi;
  logic                    x_lo;

  // Product carries 30 fraction bits; dropping 16 leaves Q2.14, ties go up.
  function automatic logic signed [16:0] round_q14(input logic signed [P_W-1:0] p);
    return 17'((p + RND) >>> 16);
  endfunction

  assign x_hi = (x_p0 > DEG_180);
  assign x_lo = (x_p0 < -DEG_180);

  // Stage p0: angle capture and wrap; stage p1: scale to radians
  always_ff @(posedge clk) begin
    case (state)
      FETCH: x_p0 <= X_W'(deg_dout);
      WRAP: begin
        if (x_hi)
          x_p0 <= x_p0 - DEG_360;
        else if (x_lo)
          x_p0 <= x_p0 + DEG_360;
      end
      MULT: theta_p1 <= round_q14(P_W'(x_p0) * K_S);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      deg_rd_en    <= 1'b0;
      theta_wr_en  <= 1'b0;
      theta_din    <= '0;
      busy         <= 1'b0;
      sample_count <= '0;
    end else begin
      deg_rd_en   <= 1'b0;
      theta_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (!deg_empty) begin
            deg_rd_en <= 1'b1;
            busy      <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: state <= WRAP;
        WRAP: begin
          if (!x_hi && !x_lo)
            state <= MULT;
        end
        MULT: state <= PUSH;
        PUSH: begin
          // Stay here while the cordic FIFO is full; nothing new is popped.
          if (!theta_full) begin
            theta_wr_en  <= 1'b1;
            theta_din    <= THETA_W'(theta_p1);
            sample_count <= sample_count + 32'd1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deg_to_theta.sv
// Bench for deg_to_theta: FIFO model on the input, reference model of the
// wrap/scale arithmetic, push-side scoreboard with latency and count checks.
module tb_deg_to_theta;

  localparam longint K_RAD = 18740330;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               deg_empty = 1'b1;
  logic               deg_rd_en;
  logic signed [15:0] deg_dout = '0;
  logic               theta_full = 1'b0;
  logic               theta_wr_en;
  logic signed [31:0] theta_din;
  logic               busy;
  logic [31:0]        sample_count;

  int     n_vec = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     rd_cyc = 0;
  bit     full_seen = 1'b0;
  int     cnt_model = 0;
  int     deg_q[$];
  longint exp_q[$];
  int     lat_q[$];

  deg_to_theta dut (
    .clk          (clk),
    .reset        (reset),
    .deg_empty    (deg_empty),
    .deg_rd_en    (deg_rd_en),
    .deg_dout     (deg_dout),
    .theta_full   (theta_full),
    .theta_wr_en  (theta_wr_en),
    .theta_din    (theta_din),
    .busy         (busy),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Wrapped angle by modular arithmetic; +180 is kept as +180.
  function automatic int ref_wrap(input int d);
    int w;
    w = ((d + 180) % 360 + 360) % 360 - 180;
    if (w == -180 && d > 0) w = 180;
    return w;
  endfunction

  function automatic int ref_steps(input int d);
    if (d > 180)  return (d - 180 + 359) / 360;
    if (d < -180) return (-180 - d + 359) / 360;
    return 0;
  endfunction

  // round(w * K / 2^16) with ties toward +inf, as a floor division.
  function automatic longint ref_theta(input int d);
    longint num;
    num = longint'(ref_wrap(d)) * K_RAD + 64'sd32768;
    if (num >= 0) return num / 65536;
    return -((-num + 65535) / 65536);
  endfunction

  task automatic push_deg(input int d);
    deg_q.push_back(d);
    exp_q.push_back(ref_theta(d));
    lat_q.push_back(4 + ref_steps(d));
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || deg_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  // Input FIFO: head is shown on deg_dout and removed on a sampled pop.
  initial begin
    bit pop;
    forever begin
      @(posedge clk);
      pop = deg_rd_en;
      #1;
      if (pop && deg_q.size() > 0) void'(deg_q.pop_front());
      deg_empty = (deg_q.size() == 0);
      deg_dout  = deg_empty ? 16'sd0 : 16'(deg_q[0]);
    end
  end

  // Output scoreboard
  always @(negedge clk) begin
    cyc++;
    if (deg_rd_en) begin
      check("rd_while_empty", deg_empty, 0);
      rd_cyc    = cyc;
      full_seen = 1'b0;
    end
    if (theta_full) full_seen = 1'b1;
    if (theta_wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_push", 1, 0);
      end else begin
        longint e;
        int     l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("theta", longint'(theta_din), e);
        if (!full_seen) check("latency", cyc - rd_cyc, l);
        cnt_model++;
        check("count", longint'(sample_count), cnt_model);
      end
    end
  end

  initial begin
    int d;
    int n;
    int pushed;
    logic signed [15:0] r;

    repeat (3) @(negedge clk);
    check("rst_rd", deg_rd_en, 0);
    check("rst_wr", theta_wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_din", longint'(theta_din), 0);
    check("rst_count", longint'(sample_count), 0);
    reset = 1'b0;

    // Empty input: nothing may move
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_rd", deg_rd_en, 0);
      check("idle_wr", theta_wr_en, 0);
      check("idle_busy", busy, 0);
    end

    push_deg(0); push_deg(90); push_deg(-90); push_deg(45);
    wait_drain(200);
    check("count_after_4", longint'(sample_count), 4);

    push_deg(180); push_deg(-180); push_deg(181);
    wait_drain(200);

    push_deg(450); push_deg(-720); push_deg(32767);
    wait_drain(500);

    // Output stall while a second sample waits in the input FIFO
    @(negedge clk);
    theta_full = 1'b1;
    push_deg(45); push_deg(90);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_wr", theta_wr_en, 0);
      check("stall_rd", deg_rd_en, 0);
      check("stall_busy", busy, 1);
    end
    theta_full = 1'b0;
    wait_drain(200);

    // Randomized angles with random back-pressure
    pushed = 0;
    n = 0;
    while (pushed < 40 && n < 6000) begin
      @(negedge clk);
      n++;
      theta_full = ($urandom_range(0, 3) == 0);
      if (deg_q.size() < 2 && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) begin
          r = 16'($urandom);
          d = r;
        end else begin
          d = int'($urandom_range(0, 800)) - 400;
        end
        push_deg(d);
        pushed++;
      end
    end
    check("rand_pushed", pushed, 40);
    theta_full = 1'b0;
    wait_drain(4000);

    // Reset in the middle of a long wrap chain
    @(negedge clk);
    push_deg(30000);
    n = 0;
    while (!deg_rd_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_rd_seen", deg_rd_en, 1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_rd", deg_rd_en, 0);
    check("arst_wr", theta_wr_en, 0);
    check("arst_busy", busy, 0);
    check("arst_din", longint'(theta_din), 0);
    check("arst_count", longint'(sample_count), 0);
    exp_q.delete();
    lat_q.delete();
    cnt_model = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push_deg(90);
    wait_drain(200);
    check("count_after_rst", longint'(sample_count), 1);
    check("theta_after_rst", longint'(theta_din), 25736);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
